// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the HH:MM:SS counter: 1 Hz enable divider, two debounced
// push-buttons, and a RUN/SET_H/SET_M/SET_S editor that presets the counter on exit.
module clock_set_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_s0,
    input  logic [2:0] cur_s1,
    input  logic [3:0] cur_m0,
    input  logic [2:0] cur_m1,
    input  logic [3:0] cur_h0,
    input  logic [1:0] cur_h1,
    output logic       en,
    output logic       load,
    output logic [3:0] sd0,
    output logic [2:0] sd1,
    output logic [3:0] md0,
    output logic [2:0] md1,
    output logic [3:0] hd0,
    output logic [2:0] hd1,
    output logic [1:0] set_mode
);

    localparam int TICK_W = $clog2(CLK_HZ);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_e;

    function automatic logic [2:0] sat_tens(input logic [2:0] t);
        return (t > 3'd5) ? 3'd5 : t;
    endfunction

    function automatic logic [3:0] sat_units(input logic [3:0] u);
        return (u > 4'd9) ? 4'd9 : u;
    endfunction

    function automatic logic [5:0] sat_hours(input logic [1:0] t, input logic [3:0] u);
        logic [1:0] tt;
        logic [3:0] uu;
        tt = (t > 2'd2) ? 2'd2 : t;
        uu = sat_units(u);
        if (tt == 2'd2 && uu > 4'd3) begin
            uu = 4'd3;
        end
        return {tt, uu};
    endfunction

    function automatic logic [5:0] inc_hours(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u >= 4'd3) begin
            return 6'd0;
        end else if (u >= 4'd9) begin
            return {t + 2'd1, 4'd0};
        end else begin
            return {t, u + 4'd1};
        end
    endfunction

    function automatic logic [6:0] inc_base60(input logic [2:0] t, input logic [3:0] u);
        if (u >= 4'd9) begin
            if (t >= 3'd5) begin
                return 7'd0;
            end else begin
                return {t + 3'd1, 4'd0};
            end
        end else begin
            return {t, u + 4'd1};
        end
    endfunction

    // Button conditioning: bit 0 = mode, bit 1 = inc
    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           lvl_q, lvl_d, lvl_prev_q;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           press;
    logic                 mode_press, inc_press;

    assign btn_raw = {btn_inc, btn_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    lvl_d[b] = ~lvl_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign press      = lvl_q & ~lvl_prev_q;
    assign mode_press = press[0];
    assign inc_press  = press[1];

    // Mode FSM
    state_e state_q, state_d;
    logic   load_q, load_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (mode_press) begin
            unique case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                ST_SET_S: begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Tick divider restarts from zero on the load cycle so seconds align to the edit exit.
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (state_q != ST_RUN || load_q || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_comb begin
        set_mode = state_q;
        load     = load_q;
        en       = tick && (state_q == ST_RUN) && !load_q;
    end

    // Edit registers
    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d;
    logic [2:0] m1_q, m1_d;
    logic [3:0] m0_q, m0_d;
    logic [2:0] s1_q, s1_d;
    logic [3:0] s0_q, s0_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= '0;
            h0_q <= '0;
            m1_q <= '0;
            m0_q <= '0;
            s1_q <= '0;
            s0_q <= '0;
        end else begin
            h1_q <= h1_d;
            h0_q <= h0_d;
            m1_q <= m1_d;
            m0_q <= m0_d;
            s1_q <= s1_d;
            s0_q <= s0_d;
        end
    end

    // Capture is clamped so the presets stay legal even if the counter feeds garbage.
    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (mode_press) begin
            if (state_q == ST_RUN) begin
                {h1_d, h0_d} = sat_hours(cur_h1, cur_h0);
                m1_d         = sat_tens(cur_m1);
                m0_d         = sat_units(cur_m0);
                s1_d         = sat_tens(cur_s1);
                s0_d         = sat_units(cur_s0);
            end
        end else if (inc_press) begin
            case (state_q)
                ST_SET_H: {h1_d, h0_d} = inc_hours(h1_q, h0_q);
                ST_SET_M: {m1_d, m0_d} = inc_base60(m1_q, m0_q);
                ST_SET_S: {s1_d, s0_d} = inc_base60(s1_q, s0_q);
                default:  ;
            endcase
        end
    end

    assign hd1 = {1'b0, h1_q};
    assign hd0 = h0_q;
    assign md1 = m1_q;
    assign md0 = m0_q;
    assign sd1 = s1_q;
    assign sd0 = s0_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with CLK_HZ=10, DEBOUNCE_CYC=4.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_s0 = '0;
    logic [2:0] cur_s1 = '0;
    logic [3:0] cur_m0 = '0;
    logic [2:0] cur_m1 = '0;
    logic [3:0] cur_h0 = '0;
    logic [1:0] cur_h1 = '0;
    logic       en, load;
    logic [3:0] sd0, md0, hd0;
    logic [2:0] sd1, md1, hd1;
    logic [1:0] set_mode;
    logic [20:0] digits;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int load_cnt = 0;

    clock_set_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_s0(cur_s0), .cur_s1(cur_s1), .cur_m0(cur_m0), .cur_m1(cur_m1),
        .cur_h0(cur_h0), .cur_h1(cur_h1),
        .en(en), .load(load),
        .sd0(sd0), .sd1(sd1), .md0(md0), .md1(md1), .hd0(hd0), .hd1(hd1),
        .set_mode(set_mode)
    );

    assign digits = {hd1, hd0, md1, md0, sd1, sd0};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en === 1'b1) en_cnt++;
        if (load === 1'b1) load_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 2 sync + 4 debounce edges, then the FSM edge: effect visible after 7 edges.
    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick(7);
    endtask

    task automatic release_btns();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(8);
    endtask

    task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0, input logic [2:0] m1,
                           input logic [3:0] m0, input logic [2:0] s1, input logic [3:0] s0);
        cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0; cur_s1 = s1; cur_s0 = s0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({en, load, set_mode, digits} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {en, load, set_mode, digits});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            if (k > 0) tick(1);
            checks++;
            if (en !== (k % 10 == 9)) begin
                errors++;
                $display("FAIL idle_en cycle %0d: got %b expected %b", k, en, (k % 10 == 9));
            end
            checks++;
            if ({load, set_mode} !== 3'd0) begin
                errors++;
                $display("FAIL idle_ctrl cycle %0d: load/set_mode got %b expected 000", k, {load, set_mode});
            end
        end
    endtask

    task automatic test_mode_bounce();
        int changes;
        logic [1:0] prev;
        changes = 0;
        set_cur(2'd2, 4'd3, 3'd5, 4'd8, 3'd5, 4'd9);
        prev = set_mode;
        for (int c = 0; c < 28; c++) begin
            btn_mode = (c == 0) || (c >= 2 && c < 13);
            tick(1);
            if (set_mode !== prev) changes++;
            prev = set_mode;
        end
        btn_mode = 1'b0;
        checks++;
        if (changes !== 1) begin
            errors++;
            $display("FAIL bounce_changes: got %0d expected 1", changes);
        end
        checks++;
        if (set_mode !== 2'd1) begin
            errors++;
            $display("FAIL bounce_state: got %0d expected 1", set_mode);
        end
        checks++;
        if (digits !== {3'd2, 4'd3, 3'd5, 4'd8, 3'd5, 4'd9}) begin
            errors++;
            $display("FAIL capture: got %h expected %h", digits, {3'd2, 4'd3, 3'd5, 4'd8, 3'd5, 4'd9});
        end
    endtask

    task automatic test_edit_hms();
        int en0;
        en0 = en_cnt;
        press(1'b0, 1'b1);
        release_btns();
        checks++;
        if (digits !== {3'd0, 4'd0, 3'd5, 4'd8, 3'd5, 4'd9}) begin
            errors++;
            $display("FAIL hour_wrap: got %h expected %h", digits, {3'd0, 4'd0, 3'd5, 4'd8, 3'd5, 4'd9});
        end
        press(1'b1, 1'b0);
        release_btns();
        checks++;
        if (set_mode !== 2'd2) begin
            errors++;
            $display("FAIL to_set_m: got %0d expected 2", set_mode);
        end
        press(1'b1, 1'b0);
        release_btns();
        checks++;
        if (set_mode !== 2'd3) begin
            errors++;
            $display("FAIL to_set_s: got %0d expected 3", set_mode);
        end
        press(1'b0, 1'b1);
        release_btns();
        checks++;
        if (digits !== {3'd0, 4'd0, 3'd5, 4'd8, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL sec_wrap: got %h expected %h", digits, {3'd0, 4'd0, 3'd5, 4'd8, 3'd0, 4'd0});
        end
        checks++;
        if (en_cnt !== en0) begin
            errors++;
            $display("FAIL en_frozen: got %0d pulses expected 0", en_cnt - en0);
        end
    endtask

    task automatic test_load_exit();
        int l0;
        press(1'b1, 1'b0);
        checks++;
        if ({load, set_mode, digits} !== {1'b1, 2'd0, 3'd0, 4'd0, 3'd5, 4'd8, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL first_exit: load/mode/digits got %h expected %h", {load, set_mode, digits},
                     {1'b1, 2'd0, 3'd0, 4'd0, 3'd5, 4'd8, 3'd0, 4'd0});
        end
        release_btns();
        set_cur(2'd0, 4'd0, 3'd0, 4'd9, 3'd0, 4'd0);
        press(1'b1, 1'b0);
        release_btns();
        press(1'b1, 1'b0);
        release_btns();
        checks++;
        if ({set_mode, digits} !== {2'd2, 3'd0, 4'd0, 3'd0, 4'd9, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL set_m_09: got %h expected %h", {set_mode, digits}, {2'd2, 3'd0, 4'd0, 3'd0, 4'd9, 3'd0, 4'd0});
        end
        press(1'b0, 1'b1);
        release_btns();
        checks++;
        if ({md1, md0} !== {3'd1, 4'd0}) begin
            errors++;
            $display("FAIL min_carry: got %h expected 10", {md1, md0});
        end
        press(1'b1, 1'b0);
        release_btns();
        l0 = load_cnt;
        press(1'b1, 1'b0);
        checks++;
        if ({load, en, set_mode} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL load_cycle: load/en/mode got %b expected 1000", {load, en, set_mode});
        end
        checks++;
        if (digits !== {3'd0, 4'd0, 3'd1, 4'd0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL presets: got %h expected %h", digits, {3'd0, 4'd0, 3'd1, 4'd0, 3'd0, 4'd0});
        end
        btn_mode = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if (en !== (k == 10)) begin
                errors++;
                $display("FAIL en_after_load +%0d: got %b expected %b", k, en, (k == 10));
            end
        end
        checks++;
        if (load_cnt - l0 !== 1) begin
            errors++;
            $display("FAIL load_count: got %0d expected 1", load_cnt - l0);
        end
        checks++;
        if (digits !== {3'd0, 4'd0, 3'd1, 4'd0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL presets_hold: got %h expected %h", digits, {3'd0, 4'd0, 3'd1, 4'd0, 3'd0, 4'd0});
        end
        tick(2);
    endtask

    task automatic test_mode_inc_same();
        set_cur(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
        press(1'b1, 1'b0);
        release_btns();
        checks++;
        if ({set_mode, digits} !== {2'd1, 3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6}) begin
            errors++;
            $display("FAIL enter_12_34_56: got %h expected %h", {set_mode, digits}, {2'd1, 3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6});
        end
        press(1'b1, 1'b1);
        release_btns();
        checks++;
        if ({set_mode, digits} !== {2'd2, 3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6}) begin
            errors++;
            $display("FAIL mode_wins: got %h expected %h", {set_mode, digits}, {2'd2, 3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6});
        end
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        press(1'b0, 1'b1);
        release_btns();
        checks++;
        if (digits !== {3'd1, 4'd2, 3'd3, 4'd5, 3'd5, 4'd6}) begin
            errors++;
            $display("FAIL min_inc: got %h expected %h", digits, {3'd1, 4'd2, 3'd3, 4'd5, 3'd5, 4'd6});
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({en, load, set_mode, digits} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {en, load, set_mode, digits});
        end
        tick(2);
        l0 = load_cnt;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick(1);
            checks++;
            if ({en, set_mode} !== {(k == 9), 2'd0}) begin
                errors++;
                $display("FAIL post_reset cycle %0d: en/mode got %b expected %b", k, {en, set_mode}, {(k == 9), 2'd0});
            end
        end
        checks++;
        if (load_cnt !== l0) begin
            errors++;
            $display("FAIL no_load_after_reset: got %0d expected 0", load_cnt - l0);
        end
    endtask

    initial begin
        test_reset();
        test_mode_bounce();
        test_edit_hms();
        test_load_exit();
        test_mode_inc_same();
        test_reset_mid_edit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
